// File: rtl/step_stim_monitor.sv
// Stimulus sequencer driving N_STEPS programmable levels into a DUT, with a
// per-step settling monitor that reports settle status and time.
module step_stim_monitor #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned N_STEPS     = 4,
  parameter int unsigned HOLD_CYCLES = 64,
  parameter int unsigned TOL         = 2,
  parameter int unsigned SETTLE_RUN  = 4,
  parameter int unsigned REPEAT      = 0,
  localparam int unsigned IW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1,
  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1),
  localparam int unsigned RW = $clog2(SETTLE_RUN + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic [N_STEPS*WIDTH-1:0]   levels,
  input  logic [WIDTH-1:0]           v_out,
  output logic [WIDTH-1:0]           v_in,
  output logic                       busy,
  output logic [IW-1:0]              step_idx,
  output logic                       step_valid,
  output logic                       settle_ok,
  output logic [CW-1:0]              settle_cyc,
  output logic                       done
);

  localparam logic [IW-1:0]        LAST_IDX = IW'(N_STEPS - 1);
  localparam logic [CW-1:0]        LAST_CNT = CW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0]        RUN_MAX  = RW'(SETTLE_RUN);
  localparam logic signed [WIDTH:0] TOL_S   = (WIDTH + 1)'(TOL);

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t            state, state_d;
  logic [WIDTH-1:0]  v_in_d;
  logic              busy_d, step_valid_d, settle_ok_d, done_d;
  logic [IW-1:0]     idx_d, idx_inc;
  logic [CW-1:0]     settle_cyc_d, cnt, cnt_d, cand, cand_d, lat, lat_d;
  logic [RW-1:0]     run, run_d;
  logic              settled, settled_d;

  logic signed [WIDTH:0] err;
  logic              in_band, hit;
  logic [RW-1:0]     run_nxt;
  logic [CW-1:0]     cand_nxt, lat_nxt;
  logic              settled_nxt;
  logic [WIDTH-1:0]  lvl_first, lvl_inc;

  // Next step index and the level it selects
  always_comb begin
    idx_inc   = (step_idx == LAST_IDX) ? '0 : step_idx + IW'(1);
    lvl_first = levels[WIDTH-1:0];
    lvl_inc   = '0;
    for (int k = 0; k < int'(N_STEPS); k++) begin
      if (IW'(k) == idx_inc) lvl_inc = levels[k*WIDTH +: WIDTH];
    end
  end

  // Band check at WIDTH+1 bits so extreme levels cannot overflow
  always_comb begin
    err         = $signed({v_out[WIDTH-1], v_out}) - $signed({v_in[WIDTH-1], v_in});
    in_band     = (err <= TOL_S) && (err >= -TOL_S);
    run_nxt     = in_band ? ((run == RUN_MAX) ? run : run + RW'(1)) : '0;
    cand_nxt    = (in_band && (run == '0)) ? cnt : cand;
    hit         = in_band && !settled && (run == RW'(SETTLE_RUN - 1));
    settled_nxt = settled | hit;
    lat_nxt     = hit ? cand_nxt : lat;
  end

  always_comb begin
    state_d      = state;
    v_in_d       = v_in;
    busy_d       = busy;
    idx_d        = step_idx;
    step_valid_d = 1'b0;
    done_d       = 1'b0;
    settle_ok_d  = settle_ok;
    settle_cyc_d = settle_cyc;
    cnt_d        = cnt;
    run_d        = run;
    cand_d       = cand;
    lat_d        = lat;
    settled_d    = settled;

    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_d   = DRIVE;
          busy_d    = 1'b1;
          idx_d     = '0;
          v_in_d    = lvl_first;
          cnt_d     = '0;
          run_d     = '0;
          cand_d    = '0;
          lat_d     = '0;
          settled_d = 1'b0;
        end
      end
      DRIVE: begin
        if (stop) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          v_in_d  = '0;
          idx_d   = '0;
        end else if (cnt == LAST_CNT) begin
          step_valid_d = 1'b1;
          settle_ok_d  = settled_nxt;
          settle_cyc_d = settled_nxt ? lat_nxt : '0;
          cnt_d        = '0;
          run_d        = '0;
          cand_d       = '0;
          lat_d        = '0;
          settled_d    = 1'b0;
          if (step_idx == LAST_IDX) begin
            done_d = 1'b1;
            if (REPEAT != 0) begin
              idx_d  = '0;
              v_in_d = lvl_first;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
              idx_d   = '0;
              v_in_d  = '0;
            end
          end else begin
            idx_d  = idx_inc;
            v_in_d = lvl_inc;
          end
        end else begin
          cnt_d     = cnt + CW'(1);
          run_d     = run_nxt;
          cand_d    = cand_nxt;
          lat_d     = lat_nxt;
          settled_d = settled_nxt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      v_in       <= '0;
      busy       <= 1'b0;
      step_idx   <= '0;
      step_valid <= 1'b0;
      settle_ok  <= 1'b0;
      settle_cyc <= '0;
      done       <= 1'b0;
      cnt        <= '0;
      run        <= '0;
      cand       <= '0;
      lat        <= '0;
      settled    <= 1'b0;
    end else begin
      state      <= state_d;
      v_in       <= v_in_d;
      busy       <= busy_d;
      step_idx   <= idx_d;
      step_valid <= step_valid_d;
      settle_ok  <= settle_ok_d;
      settle_cyc <= settle_cyc_d;
      done       <= done_d;
      cnt        <= cnt_d;
      run        <= run_d;
      cand       <= cand_d;
      lat        <= lat_d;
      settled    <= settled_d;
    end
  end

endmodule
